// File: rtl/uart_loader.sv
// uart_loader: receives a UART 8N1 stream, packs little-endian 32-bit words and
// writes them to the memory programming port until the header word count is exhausted.
module uart_loader #(
  parameter int CLK_FREQ = 23_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_i,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        busy_o,
  output logic        frame_err_o
);
  localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = $clog2(DIV + 1);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
  typedef enum logic [1:0] {HDR0, HDR1, LOAD, DONE} ld_st_t;
  logic          rx_meta_q, rx_q;
  logic [DW-1:0] div_q, div_d;
  logic          tick;
  rx_st_t        rxs_q, rxs_d;
  logic [3:0]    tcnt_q, tcnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    sh_q, sh_d;
  logic          bvld_q, bvld_d;
  logic          ferr_q, ferr_d;
  ld_st_t        ls_q, ls_d;
  logic [14:0]   n_q, n_d;
  logic [1:0]    bidx_q, bidx_d;
  logic [31:0]   word_q, word_d;
  logic [14:0]   idx_q, idx_d;
  logic [14:0]   cnt_q, cnt_d;
  logic          wen_q, wen_d;
  logic [14:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          done_q, done_d;
  assign tick        = (div_q == DW'(DIV - 1));
  assign div_d       = tick ? '0 : div_q + 1'b1;
  assign upg_wen_o   = wen_q;
  assign upg_adr_o   = adr_q;
  assign upg_dat_o   = dat_q;
  assign upg_done_o  = done_q;
  assign busy_o      = (ls_q == LOAD);
  assign frame_err_o = ferr_q;
  // Receiver: start detected on a tick, centre-sampled 8 ticks later, then every 16
  always_comb begin
    rxs_d  = rxs_q;
    tcnt_d = tcnt_q;
    bcnt_d = bcnt_q;
    sh_d   = sh_q;
    bvld_d = 1'b0;
    ferr_d = ferr_q;
    if (tick) begin
      case (rxs_q)
        R_IDLE: begin
          rxs_d  = rx_q ? R_IDLE : R_START;
          tcnt_d = '0;
        end
        R_START: begin
          tcnt_d = (tcnt_q == 4'd7) ? 4'd0 : tcnt_q + 4'd1;
          if (tcnt_q == 4'd7) rxs_d = rx_q ? R_IDLE : R_DATA;
        end
        R_DATA: begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            sh_d   = {rx_q, sh_q[7:1]};
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) rxs_d = R_STOP;
          end
        end
        default: begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            rxs_d  = R_IDLE;
            bvld_d = rx_q;
            ferr_d = ferr_q | ~rx_q;
          end
        end
      endcase
    end
  end
  always_comb begin
    ls_d   = ls_q;
    n_d    = n_q;
    bidx_d = bidx_q;
    word_d = word_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    wen_d  = 1'b0;
    adr_d  = adr_q;
    dat_d  = dat_q;
    done_d = done_q | (wen_q && ls_q == DONE);
    if (bvld_q) begin
      case (ls_q)
        HDR0: begin
          n_d  = {n_q[14:8], sh_q};
          ls_d = HDR1;
        end
        HDR1: begin
          n_d = {sh_q[6:0], n_q[7:0]};
          if ({sh_q[6:0], n_q[7:0]} == 15'd0) begin
            ls_d   = DONE;
            done_d = 1'b1;
          end else begin
            ls_d = LOAD;
          end
        end
        LOAD: begin
          word_d = {sh_q, word_q[31:8]};
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            wen_d = 1'b1;
            adr_d = idx_q;
            dat_d = {sh_q, word_q[31:8]};
            idx_d = idx_q + 15'd1;
            cnt_d = cnt_q + 15'd1;
            if (cnt_q + 15'd1 == n_q) ls_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end
  // Synchronizer flops reset to the idle-high line level so reset cannot fake a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_q      <= 1'b1;
      div_q     <= '0;
      rxs_q     <= R_IDLE;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      sh_q      <= '0;
      bvld_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ls_q      <= HDR0;
      n_q       <= '0;
      bidx_q    <= '0;
      word_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      wen_q     <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_q      <= rx_meta_q;
      div_q     <= div_d;
      rxs_q     <= rxs_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      sh_q      <= sh_d;
      bvld_q    <= bvld_d;
      ferr_q    <= ferr_d;
      ls_q      <= ls_d;
      n_q       <= n_d;
      bidx_q    <= bidx_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      wen_q     <= wen_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      done_q    <= done_d;
    end
  end
endmodule
